// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating multiplexer. A fixed-priority or
// round-robin arbiter picks one valid producer, and the winning beat is
// captured in a single output register that holds until the sink accepts it.
module rr_arb_mux #(
   parameter  int WIDTH = 4,
   parameter  int NCH   = 4,
   localparam int SEL_W = (NCH > 2) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic [NCH-1:0]       in_ready,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]     out_sel,
   output logic [NCH-1:0]       out_grant
);

   // Pointer starts at the last channel so the first round-robin grant is 0.
   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NCH - 1);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_ptr;
   logic [NCH-1:0]   r_grant;

   logic             w_ld;
   logic             w_any;
   logic [SEL_W-1:0] w_win;
   logic [NCH-1:0]   w_win_oh;
   logic [WIDTH-1:0] w_data;

   // The output register can take a new beat when empty or being drained.
   assign w_ld = !r_valid || out_ready;

   // Winner search. Loops run from the far end down so the highest-priority
   // candidate is the last one assigned. In round-robin the candidate index
   // is ptr+k folded once at NCH (ptr < NCH, k <= NCH), so the search wraps
   // at NCH even when NCH is not a power of two.
   always_comb begin
      int idx;
      w_any = 1'b0;
      w_win = '0;
      idx   = 0;
      if (!mode) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[SEL_W'(i)]) begin
               w_any = 1'b1;
               w_win = SEL_W'(i);
            end
         end
      end else begin
         for (int k = NCH; k >= 1; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (in_valid[SEL_W'(idx)]) begin
               w_any = 1'b1;
               w_win = SEL_W'(idx);
            end
         end
      end
   end

   // Decode the winner and gate the per-channel accept. Reset forces all
   // accepts low so nothing is consumed while the register is cleared.
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign w_win_oh[g] = (w_win == SEL_W'(g));
      assign in_ready[g] = rst_n && w_ld && w_any && w_win_oh[g];
   end

   // Data mux of the winning channel.
   always_comb begin
      w_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_win == SEL_W'(i)) w_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output stage and fairness pointer: load on transfer, empty on idle
   // load (data/sel keep their last values), hold everything otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_grant <= '0;
         r_ptr   <= PTR_RST;
      end else if (w_ld) begin
         if (w_any) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_sel   <= w_win;
            r_grant <= w_win_oh;
            r_ptr   <= w_win;
         end else begin
            r_valid <= 1'b0;
            r_grant <= '0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_grant = r_grant;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the arbitration rules.
module tb_rr_arb_mux;
   localparam int W  = 4;
   localparam int N  = 4;
   localparam int SW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           mode = 1'b0;
   logic           out_ready = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_sel;
   logic [N-1:0]   out_grant;

   // Second instance with a non-power-of-two channel count.
   logic           b_mode = 1'b1;
   logic           b_out_ready = 1'b1;
   logic [2:0]     b_in_valid = '0;
   logic [11:0]    b_in_data = '0;
   logic [2:0]     b_in_ready;
   logic           b_out_valid;
   logic [3:0]     b_out_data;
   logic [1:0]     b_out_sel;
   logic [2:0]     b_out_grant;

   int checks = 0;
   int errors = 0;

   rr_arb_mux #(.WIDTH(W), .NCH(N)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .out_grant(out_grant));

   rr_arb_mux #(.WIDTH(4), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid),
      .in_data(b_in_data), .in_ready(b_in_ready), .out_ready(b_out_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_sel(b_out_sel),
      .out_grant(b_out_grant));

   always #5 clk = ~clk;

   // Reference model: one held beat plus the index of the last winner.
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_sel;
   int           m_ptr;

   function automatic int winner(int nch, bit md, logic [N-1:0] v, int ptr);
      if (!md) begin
         for (int i = 0; i < nch; i++) if (v[i]) return i;
         return -1;
      end
      for (int k = 1; k <= nch; k++) if (v[(ptr + k) % nch]) return (ptr + k) % nch;
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready();
      int w;
      w = winner(N, mode, in_valid, m_ptr);
      if ((m_valid && !out_ready) || w < 0) return '0;
      return N'(1) << w;
   endfunction

   function automatic logic [N-1:0] m_grant();
      return m_valid ? (N'(1) << m_sel) : '0;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = N - 1;
   endtask

   task automatic model_edge();
      int w;
      w = winner(N, mode, in_valid, m_ptr);
      if (!m_valid || out_ready) begin
         if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[w*W +: W];
            m_sel   = w;
            m_ptr   = w;
         end else begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; model_reset();
      mode = 1'b0; out_ready = 1'b0; in_valid = 4'b0100; in_data = 16'h0900;
      tick();
      checks++;
      if ({out_valid, out_data, out_sel} !== {1'b1, 4'h9, 2'd2}) begin
         errors++; $display("FAIL rst_preload got %b/%h/%0d exp 1/9/2", out_valid, out_data, out_sel);
      end
      #2 rst_n = 1'b0; in_valid = 4'b1111; model_reset();
      #1;
      checks++;
      if ({out_valid, out_data, out_sel, out_grant, in_ready} !== '0) begin
         errors++; $display("FAIL rst_async got %b %h %0d %b %b exp all 0", out_valid, out_data, out_sel, out_grant, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, out_sel, out_grant, in_ready} !== '0) begin
         errors++; $display("FAIL rst_hold got %b %h %0d %b %b exp all 0", out_valid, out_data, out_sel, out_grant, in_ready);
      end
      #2 in_valid = '0; mode = 1'b1; out_ready = 1'b1; rst_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({out_valid, out_data, out_sel, out_grant} !== '0) begin
            errors++; $display("FAIL rst_idle got %b %h %0d %b exp all 0", out_valid, out_data, out_sel, out_grant);
         end
      end
      in_valid = 4'b1111; in_data = 16'h4321;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL rst_first_rr_ready got %b exp 0001", in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_grant, out_data} !== {1'b1, 2'd0, 4'b0001, 4'h1}) begin
         errors++; $display("FAIL rst_first_rr got %b %0d %b %h exp 1 0 0001 1", out_valid, out_sel, out_grant, out_data);
      end
   endtask

   task automatic test_fixed();
      mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1110; in_data = 16'hCBA0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL fixed_ready got %b exp 0010", in_ready);
         end
         tick();
         checks++;
         if ({out_valid, out_data, out_sel, out_grant} !== {1'b1, 4'hA, 2'd1, 4'b0010}) begin
            errors++; $display("FAIL fixed_out got %b %h %0d %b exp 1 A 1 0010", out_valid, out_data, out_sel, out_grant);
         end
      end
   endtask

   task automatic test_rr();
      int hits [N];
      int prev;
      foreach (hits[i]) hits[i] = 0;
      mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
      prev = m_sel;
      for (int c = 0; c < 8; c++) begin
         in_data = 16'($urandom);
         #1;
         for (int i = 0; i < N; i++) if (in_ready[i]) hits[i]++;
         tick();
         checks++;
         if (out_sel !== SW'((prev + 1) % N) || out_data !== m_data || !out_valid) begin
            errors++; $display("FAIL rr_seq got sel %0d data %h exp sel %0d data %h", out_sel, out_data, (prev + 1) % N, m_data);
         end
         prev = (prev + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (hits[i] != 2) begin
            errors++; $display("FAIL rr_fair ch%0d got %0d grants exp 2", i, hits[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] d0;
      mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0100; in_data = 16'h0700;
      tick();
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         in_data = 16'($urandom);
         #1;
         checks++;
         if ({in_ready, out_valid, out_data, out_sel, out_grant} !== {4'b0000, 1'b1, 4'h7, 2'd2, 4'b0100}) begin
            errors++; $display("FAIL bp_hold got rdy %b v %b d %h sel %0d g %b exp 0000 1 7 2 0100",
                               in_ready, out_valid, out_data, out_sel, out_grant);
         end
         tick();
      end
      out_ready = 1'b1; d0 = in_data[3:0];
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin
         errors++; $display("FAIL bp_release_ready got %b exp 0001", in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, d0}) begin
         errors++; $display("FAIL bp_release got %b %0d %h exp 1 0 %h", out_valid, out_sel, out_data, d0);
      end
   endtask

   task automatic test_wrap();
      b_mode = 1'b1; b_out_ready = 1'b1; b_in_valid = 3'b101; b_in_data = 12'h5A3;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         checks++;
         if (b_out_valid !== 1'b1 || b_out_sel !== ((c % 2 == 0) ? 2'd0 : 2'd2) ||
             b_out_data !== ((c % 2 == 0) ? 4'h3 : 4'h5)) begin
            errors++; $display("FAIL wrap3 got v %b sel %0d d %h exp sel %0d", b_out_valid, b_out_sel, b_out_data, (c % 2 == 0) ? 0 : 2);
         end
      end
      b_in_valid = '0;
   endtask

   task automatic test_mode_switch();
      mode = 1'b0; out_ready = 1'b1; in_valid = 4'b0011; in_data = 16'h00E5;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 4'h5}) begin
            errors++; $display("FAIL ms_fixed got %b %0d %h exp 1 0 5", out_valid, out_sel, out_data);
         end
      end
      mode = 1'b1; in_valid = '0;
      tick();
      checks++;
      if ({out_valid, out_grant, out_sel, out_data} !== {1'b0, 4'b0000, 2'd0, 4'h5}) begin
         errors++; $display("FAIL ms_gap got v %b g %b sel %0d d %h exp 0 0000 0 5", out_valid, out_grant, out_sel, out_data);
      end
      in_valid = 4'b0011;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
         errors++; $display("FAIL ms_rr_ready got %b exp 0010", in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_sel, out_grant, out_data} !== {1'b1, 2'd1, 4'b0010, 4'hE}) begin
         errors++; $display("FAIL ms_rr got %b %0d %b %h exp 1 1 0010 E", out_valid, out_sel, out_grant, out_data);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         mode      = 1'($urandom);
         in_valid  = 4'($urandom);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (in_ready !== m_ready()) begin
            errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", c, in_ready, m_ready());
         end
         tick();
         checks++;
         if ({out_valid, out_data, out_sel, out_grant} !== {m_valid, m_data, SW'(m_sel), m_grant()}) begin
            errors++; $display("FAIL rand_out cyc %0d got %b %h %0d %b exp %b %h %0d %b", c,
                               out_valid, out_data, out_sel, out_grant, m_valid, m_data, m_sel, m_grant());
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_fixed();
      test_rr();
      test_backpressure();
      test_wrap();
      test_mode_switch();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes and a registered output stage. It is the next generation of the team's decoder-based 4:1 mux. Channel selection is no longer driven by an external select. An internal arbiter, either fixed-priority or round-robin, picks the channel and encodes it as a one-hot grant. The winning beat is held in a single output register until the consumer accepts it. The block sits between multiple data producers and a single shared downstream sink.

## Interface

Parameters:
- WIDTH, 4, data bits per channel (>= 1)
- NCH, 4, number of input channels (>= 2; need not be a power of two)
- SEL_W, derived localparam = max(1, clog2(NCH)), width of the channel index

Ports:
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- in_valid  in  NCH  per-channel valid; bit i belongs to channel i
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NCH  per-channel accept; combinational; at most one bit set
- out_valid  out  1  the output register holds a beat
- out_data  out  WIDTH  held beat data
- out_sel  out  SEL_W  index of the channel that supplied the held beat
- out_grant  out  NCH  one-hot copy of out_sel (decoded); all zero when out_valid = 0

## Operation

- Load enable: ld = !out_valid || out_ready.
- Winner (combinational):
  - mode = 0: the lowest i with in_valid[i] = 1.
  - mode = 1: the first i with in_valid[i] = 1, searching ptr+1, ptr+2, … modulo NCH. The search wraps at NCH, not at 2^SEL_W.
- in_ready[w] = ld && in_valid[w] for the winner w. All other bits are 0.
- A transfer on channel i occurs when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data of channel i.
  - out_sel <= i.
  - out_grant <= (1 << i).
  - out_valid <= 1.
  - ptr <= i.
- ld = 1 with no in_valid: out_valid <= 0 and out_grant <= 0. out_data and out_sel hold their previous values.
- ld = 0: all output registers and ptr hold.
- Output hold rule: while out_valid = 1 and out_ready = 0, out_data, out_sel and out_grant must not change.
- ptr updates in both modes. A later switch to mode = 1 therefore continues fairly from the last winner.
- mode is sampled combinationally each cycle. A change affects the next arbitration only and never disturbs a held beat.
- Producers must not make in_valid depend on in_ready. in_ready depends combinationally on in_valid, mode, ptr, out_valid and out_ready.

## Timing

- Reset values (asynchronous, while rst_n = 0):
  - out_valid = 0
  - out_data = 0
  - out_sel = 0
  - out_grant = 0
  - ptr = NCH-1, so the first round-robin grant goes to channel 0.
- Reset mid-operation: any held beat is discarded. in_ready is all zero while rst_n = 0.
- Latency: a beat accepted on edge k is visible on out_* after edge k. Latency is 1 cycle.
- Throughput: 1 beat per cycle when out_ready is held at 1. No bubble is inserted between consecutive beats.
- Simultaneous drain and fill: with out_valid = 1, out_ready = 1 and a valid input, the old beat leaves and the new beat loads on the same edge.
- Round-robin fairness: with all NCH inputs continuously valid and out_ready = 1, each channel is granted exactly once in every window of NCH consecutive grants.

## Test plan

- Reset and idle:
  - Stimulus: assert rst_n = 0 mid-stream while out_valid = 1, then release with no in_valid.
  - Required: all outputs are 0 immediately and stay 0. The first mode = 1 grant, with in_valid = 4'b1111, goes to channel 0.
- Fixed priority:
  - Stimulus: NCH = 4, WIDTH = 4, mode = 0, in_valid = 4'b1110, data c1 = 4'hA, c2 = 4'hB, c3 = 4'hC, out_ready = 1.
  - Required: channel 1 wins every cycle; out_data = 4'hA, out_sel = 1, out_grant = 4'b0010 one cycle later.
- Round-robin rotation:
  - Stimulus: mode = 1, in_valid = 4'b1111, out_ready = 1.
  - Required: out_sel sequence 0,1,2,3,0,1…; each in_ready bit is high once per 4 cycles.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles after a beat from channel 2 (data 4'h7).
  - Required: out_data = 4'h7, out_sel = 2 and in_ready = 0 for all 5 cycles. On the first out_ready = 1 cycle, the next winner is accepted on the same edge.
- Non-power-of-two wrap:
  - Stimulus: NCH = 3, mode = 1, in_valid = 3'b101, out_ready = 1.
  - Required: out_sel alternates 0,2,0,2. Index 3 is never produced.
- Mode switch with drain gap:
  - Stimulus: run mode = 0 with in_valid = 4'b0011 for 2 grants (ptr = 0), switch to mode = 1, then drop in_valid to 0 for one cycle.
  - Required: the next grant after the switch is channel 1. out_valid = 0 and out_grant = 0 for the gap cycle.
